// File: rtl/line_fetch_sched_pkg.sv
// line_fetch_pkg: scheduler state encoding, DRAM word width and the per-line
// derived constants (words, commands, line stride, command step).
package line_fetch_pkg;

    localparam int WORD_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // A 128-bit word carries 4 pixels at 32 bpp.
    function automatic int calc_wpl(input int h_active);
        return h_active / 4;
    endfunction

    function automatic int calc_cpl(input int h_active, input int burst_len);
        return h_active / 4 / burst_len;
    endfunction

    function automatic int calc_stride(input int h_active);
        return h_active * 4;
    endfunction

    function automatic int calc_cmd_step(input int burst_len);
        return burst_len * 16;
    endfunction

endpackage

// File: rtl/lf_addr_gen.sv
// lf_addr_gen: line start and burst command byte addresses, both wrapping
// modulo 2^ADDR_W.
module lf_addr_gen #(
    parameter int ADDR_W   = 28,
    parameter int STRIDE   = 5120,
    parameter int CMD_STEP = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic              base_load,
    input  logic              line_step,
    input  logic              cmd_load,
    input  logic              cmd_step,
    output logic [ADDR_W-1:0] cmd_addr
);

    logic [ADDR_W-1:0] line_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_addr <= '0;
            cmd_addr  <= '0;
        end else begin
            line_addr <= base_load ? frame_base :
                         line_step ? line_addr + ADDR_W'(STRIDE) : line_addr;
            cmd_addr  <= cmd_load ? line_addr :
                         cmd_step ? cmd_addr + ADDR_W'(CMD_STEP) : cmd_addr;
        end
    end

endmodule

// File: rtl/line_fetch_sched.sv
// line_fetch_sched: issues the burst reads for each active video line and
// steers returned words into one half of a ping-pong line buffer.
module line_fetch_sched
    import line_fetch_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int ADDR_W    = 28,
    parameter int BURST_LEN = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [ADDR_W-1:0]           frame_base,
    input  logic                        framestart_i,
    input  logic                        prefetch_line_i,
    output logic                        rd_cmd_valid,
    input  logic                        rd_cmd_ready,
    output logic [ADDR_W-1:0]           rd_cmd_addr,
    output logic [7:0]                  rd_cmd_len,
    input  logic                        rd_data_valid,
    input  logic [WORD_W-1:0]           rd_data,
    output logic                        lb_wr_en,
    output logic [$clog2(H_ACTIVE/4):0] lb_wr_addr,
    output logic [WORD_W-1:0]           lb_wr_data,
    output logic                        line_done,
    output logic                        busy,
    output logic                        underrun
);

    localparam int WPL  = calc_wpl(H_ACTIVE);
    localparam int CPL  = calc_cpl(H_ACTIVE, BURST_LEN);
    localparam int WA_W = $clog2(WPL);
    localparam int WC_W = $clog2(WPL + 1);
    localparam int CC_W = $clog2(CPL + 1);
    localparam int LI_W = $clog2(V_ACTIVE + 1);

    state_t          state, state_n;
    logic [CC_W-1:0] cmd_cnt;
    logic [WC_W-1:0] word_cnt;
    logic [LI_W-1:0] line_idx;
    logic            bank, restart_pend;
    logic            active, fire, wr, done, restart, start, base_load, line_step;

    always_comb begin
        active    = state == ST_ISSUE || state == ST_DRAIN;
        fire      = state == ST_ISSUE && rd_cmd_valid && rd_cmd_ready;
        wr        = active && rd_data_valid;
        // Complete on the edge that writes the last word so line_done lines up with it.
        done      = state == ST_DRAIN &&
                    (word_cnt == WC_W'(WPL) || (wr && word_cnt == WC_W'(WPL - 1)));
        restart   = restart_pend || framestart_i;
        start     = state == ST_WAIT && enable && !framestart_i && prefetch_line_i &&
                    line_idx < LI_W'(V_ACTIVE);
        base_load = ((state == ST_IDLE || state == ST_WAIT) && enable && framestart_i) ||
                    (done && restart);
        line_step = done && !restart;
        state_n   = state == ST_IDLE  ? (enable && framestart_i ? ST_WAIT : ST_IDLE) :
                    state == ST_WAIT  ? (!enable ? ST_IDLE : start ? ST_ISSUE : ST_WAIT) :
                    state == ST_ISSUE ? (fire && cmd_cnt == CC_W'(CPL - 1) ? ST_DRAIN : ST_ISSUE) :
                    done ? (enable ? ST_WAIT : ST_IDLE) : ST_DRAIN;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cmd_cnt      <= '0;
            word_cnt     <= '0;
            line_idx     <= '0;
            bank         <= 1'b0;
            restart_pend <= 1'b0;
            rd_cmd_valid <= 1'b0;
            rd_cmd_len   <= '0;
            lb_wr_en     <= 1'b0;
            lb_wr_addr   <= '0;
            lb_wr_data   <= '0;
            line_done    <= 1'b0;
            busy         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_n;
            cmd_cnt      <= start ? '0 : fire ? cmd_cnt + 1'b1 : cmd_cnt;
            word_cnt     <= start ? '0 : wr ? word_cnt + 1'b1 : word_cnt;
            line_idx     <= base_load ? '0 : line_step ? line_idx + 1'b1 : line_idx;
            bank         <= base_load ? 1'b0 : line_step ? ~bank : bank;
            // A frame start during a line is deferred: DRAM reads cannot be cancelled.
            restart_pend <= active && !done && restart;
            rd_cmd_valid <= state_n == ST_ISSUE;
            rd_cmd_len   <= 8'(BURST_LEN - 1);
            lb_wr_en     <= wr;
            if (wr) begin
                lb_wr_addr <= {bank, word_cnt[WA_W-1:0]};
                lb_wr_data <= rd_data;
            end
            line_done    <= done;
            busy         <= state_n == ST_ISSUE || state_n == ST_DRAIN;
            underrun     <= underrun || (active && prefetch_line_i);
        end
    end

    lf_addr_gen #(
        .ADDR_W  (ADDR_W),
        .STRIDE  (calc_stride(H_ACTIVE)),
        .CMD_STEP(calc_cmd_step(BURST_LEN))
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .frame_base(frame_base),
        .base_load (base_load),
        .line_step (line_step),
        .cmd_load  (start),
        .cmd_step  (fire),
        .cmd_addr  (rd_cmd_addr)
    );

endmodule

// File: tb/tb_line_fetch_sched.sv
// tb_line_fetch_sched: directed scenarios with randomized DRAM latency, ready
// and stray data, checked against a line-level reference model.
module tb_line_fetch_sched;

    localparam int H        = 256;
    localparam int V        = 16;
    localparam int BL       = 8;
    localparam int WPL      = H / 4;
    localparam int CPL      = WPL / BL;
    localparam int STRIDE   = H * 4;
    localparam int CMD_STEP = BL * 16;
    localparam int WA       = $clog2(WPL);

    typedef enum int {M_IDLE, M_WAIT, M_LINE} mph_t;

    logic          clk = 0;
    logic          rst, enable, fs, pf, rdy, dv;
    logic [27:0]   frame_base;
    logic [127:0]  rd_data;
    logic          rd_cmd_valid, lb_wr_en, line_done, busy, underrun;
    logic [27:0]   rd_cmd_addr;
    logic [7:0]    rd_cmd_len;
    logic [WA:0]   lb_wr_addr;
    logic [127:0]  lb_wr_data;

    int tests = 0, fails = 0, cyc = 0, next_free = 0, rdy_mode = 0;
    int dut_cmds = 0, dut_wrs = 0, seen_done = 0;
    int ret_q[$];
    mph_t         ph = M_IDLE;
    logic [27:0]  m_base = '0;
    int           m_idx = 0, m_cmds = 0, m_words = 0;
    bit           m_pend = 0, m_under = 0;
    bit           e_wr = 0, e_done = 0, e_valid = 0;
    logic [WA:0]  e_waddr = '0;
    logic [127:0] e_wdata = '0;
    logic [27:0]  first_addr = '0, last_addr = '0;
    logic [WA:0]  done_addr = '0;

    line_fetch_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(28), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_base(frame_base),
        .framestart_i(fs), .prefetch_line_i(pf),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rdy), .rd_cmd_addr(rd_cmd_addr),
        .rd_cmd_len(rd_cmd_len), .rd_data_valid(dv), .rd_data(rd_data),
        .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
        .line_done(line_done), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected address of the next command: frame base, whole lines, then bursts.
    function automatic logic [27:0] cmd_exp();
        return m_base + 28'(m_idx * STRIDE) + 28'(m_cmds * CMD_STEP);
    endfunction

    task automatic step();
        bit fire, wr, done;
        int t;
        dv = 0;
        rd_data = '0;
        if (ret_q.size() != 0 && ret_q[0] <= cyc) begin
            void'(ret_q.pop_front());
            dv = 1;
            rd_data = {$urandom, $urandom, $urandom, $urandom};
        end else if (ph != M_LINE && $urandom_range(3) == 0) begin
            dv = 1;
            rd_data = {$urandom, $urandom, $urandom, $urandom};
        end
        rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(1));
        if (rst && rd_cmd_valid && rdy) dut_cmds++;
        if (!rst) begin
            ph = M_IDLE; m_base = '0; m_idx = 0; m_cmds = 0; m_words = 0;
            m_pend = 0; m_under = 0; e_wr = 0; e_done = 0; e_waddr = '0; e_wdata = '0;
        end else begin
            fire = ph == M_LINE && m_cmds < CPL && rdy;
            wr = ph == M_LINE && dv;
            e_wr = wr;
            if (wr) begin
                e_waddr = {m_idx[0], m_words[WA-1:0]};
                e_wdata = rd_data;
                m_words++;
            end
            done = wr && m_cmds == CPL && m_words == WPL;
            e_done = done;
            if (ph == M_LINE && pf) m_under = 1;
            if (ph == M_LINE && fs) m_pend = 1;
            if (fire) begin
                last_addr = rd_cmd_addr;
                t = cyc + $urandom_range(10, 3);
                if (next_free > t) t = next_free;
                for (int k = 0; k < BL; k++) ret_q.push_back(t + k);
                next_free = t + BL;
                m_cmds++;
            end
            case (ph)
                M_IDLE: if (enable && fs) begin m_base = frame_base; m_idx = 0; ph = M_WAIT; end
                M_WAIT: begin
                    if (!enable) ph = M_IDLE;
                    else if (fs) begin m_base = frame_base; m_idx = 0; end
                    else if (pf && m_idx < V) begin ph = M_LINE; m_cmds = 0; m_words = 0; end
                end
                default: if (done) begin
                    if (m_pend) begin m_base = frame_base; m_idx = 0; end
                    else m_idx++;
                    m_pend = 0;
                    ph = enable ? M_WAIT : M_IDLE;
                end
            endcase
        end
        e_valid = ph == M_LINE && m_cmds < CPL;
        @(posedge clk);
        #1;
        cyc++;
        fs = 0;
        pf = 0;
        if (lb_wr_en) dut_wrs++;
        if (line_done) begin seen_done++; done_addr = lb_wr_addr; end
        if (e_valid && m_cmds == 0) first_addr = rd_cmd_addr;
        chk("cmd_valid", rd_cmd_valid, e_valid);
        chk("busy", busy, ph == M_LINE);
        chk("wr_en", lb_wr_en, e_wr);
        chk("line_done", line_done, e_done);
        chk("underrun", underrun, m_under);
        chk("wr_addr", lb_wr_addr, e_waddr);
        chk("wr_data", lb_wr_data, e_wdata);
        if (e_valid) begin
            chk("cmd_addr", rd_cmd_addr, cmd_exp());
            chk("cmd_len", rd_cmd_len, BL - 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, rd_cmd_valid, 0);
        chk({tag, "_addr"}, rd_cmd_addr, 0);
        chk({tag, "_len"}, rd_cmd_len, 0);
        chk({tag, "_wr_en"}, lb_wr_en, 0);
        chk({tag, "_wr_addr"}, lb_wr_addr, 0);
        chk({tag, "_wr_data"}, lb_wr_data, 0);
        chk({tag, "_done"}, line_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_underrun"}, underrun, 0);
    endtask

    task automatic run_line(input int rmode, input bit pf_drain, input bit fs_issue, input bit en_drop);
        int n = 0;
        bit inj_pf = 0, inj_fs = 0, inj_en = 0;
        rdy_mode = rmode;
        pf = 1;
        step();
        while (ph == M_LINE && n < 3000) begin
            if (!inj_pf && pf_drain && m_cmds == CPL && m_words == WPL / 2) begin pf = 1; inj_pf = 1; end
            if (!inj_fs && fs_issue && m_cmds == 2) begin fs = 1; frame_base = 28'h200_0000; inj_fs = 1; end
            if (!inj_en && en_drop && m_cmds == 4) begin enable = 0; inj_en = 1; end
            step();
            n++;
        end
        chk("line_timeout", ph == M_LINE, 0);
    endtask

    initial begin
        int d0, c0, w0, n;
        rst = 0; enable = 0; fs = 0; pf = 0; rdy = 0; dv = 0; rd_data = '0; frame_base = '0;
        idle(2);
        check_zero("reset");
        rst = 1;
        step();
        // Single line
        enable = 1; frame_base = 28'h100_0000; fs = 1;
        step();
        idle(3);
        d0 = seen_done; c0 = dut_cmds;
        run_line(0, 0, 0, 0);
        chk("t1_first_addr", first_addr, 28'h100_0000);
        chk("t1_last_addr", last_addr, 28'h100_0380);
        chk("t1_cmds", dut_cmds - c0, CPL);
        chk("t1_done_addr", done_addr, 7'h3f);
        chk("t1_done_cnt", seen_done - d0, 1);
        // Second line with stalled ready, prefetch one cycle after line_done
        idle(1);
        run_line(1, 0, 0, 0);
        chk("t2_first_addr", first_addr, 28'h100_0400);
        chk("t2_done_addr", done_addr, 7'h7f);
        // Frame start during ISSUE
        idle(2);
        run_line(2, 0, 1, 0);
        chk("t4_cur_addr", first_addr, 28'h100_0800);
        chk("t4_cur_done", done_addr, 7'h3f);
        idle(2);
        run_line(0, 0, 0, 0);
        chk("t4_new_addr", first_addr, 28'h200_0000);
        chk("t4_new_bank", done_addr, 7'h3f);
        // End of frame
        for (int i = 1; i < V; i++) begin
            idle(1);
            run_line(2, 0, 0, 0);
        end
        c0 = dut_cmds;
        pf = 1;
        step();
        idle(5);
        chk("t5_no_cmd", dut_cmds - c0, 0);
        chk("t5_underrun", underrun, 0);
        chk("t5_busy", busy, 0);
        // Prefetch during DRAIN, enable dropped mid-line
        fs = 1;
        step();
        idle(1);
        c0 = dut_cmds; d0 = seen_done;
        run_line(0, 1, 0, 1);
        chk("t3_underrun", underrun, 1);
        chk("t3_cmds", dut_cmds - c0, CPL);
        chk("t3_done_cnt", seen_done - d0, 1);
        pf = 1;
        step();
        idle(3);
        chk("t3_sticky", underrun, 1);
        chk("t3_idle", busy, 0);
        // Reset mid-line
        enable = 1; frame_base = 28'h300_0000; fs = 1;
        step();
        idle(1);
        rdy_mode = 2;
        pf = 1;
        step();
        n = 0;
        while (m_cmds < 3 && n < 100) begin step(); n++; end
        chk("t6_reach_issue", m_cmds >= 3, 1);
        rst = 0;
        step();
        check_zero("t6_reset");
        rst = 1;
        w0 = dut_wrs;
        n = 0;
        while (ret_q.size() != 0 && n < 200) begin step(); n++; end
        chk("t6_late_dropped", dut_wrs - w0, 0);
        // Recovery with address wrap
        enable = 1; frame_base = 28'hFFF_FC00; fs = 1;
        step();
        idle(1);
        run_line(2, 0, 0, 0);
        chk("t7_first_addr", first_addr, 28'hFFF_FC00);
        idle(1);
        run_line(0, 0, 0, 0);
        chk("t7_wrap_addr", first_addr, 28'h000_0000);
        chk("t7_wrap_bank", done_addr, 7'h7f);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
